armleocpu_axi_arbiter: RTL and testbench
========================================

// Module: armleocpu_axi_arbiter
// PURPOSE
//  N-to-1 AXI4 arbiter: lets OPT_NUMBER_OF_HOSTS AXI masters (CPU, DMA, debug) share one
//  downstream AXI4 port, typically the input of the 1-to-N router. Read and write channels
//  are arbitrated independently, round-robin. One outstanding burst per channel.
//  IDs pass through unchanged; the response is routed back by the registered grant.
// PARAMETERS
//  ADDR_WIDTH           34  address width
//  DATA_WIDTH           32  data width; DATA_STROBES = DATA_WIDTH/8
//  ID_WIDTH             4   AXI ID width, same on both sides
//  OPT_NUMBER_OF_HOSTS  2   upstream masters, >=1; GW = max(1,$clog2(N))
// PORTS  (client_* ports are per-master, packed, master i at slice i; host_* is the single downstream port)
//  clk                                         in   1       clock, all logic posedge
//  rst                                         in   1       synchronous active-high reset
//  client_axi_{aw,ar}valid / {aw,ar}ready      in/out N     address handshakes
//  client_axi_{aw,ar}addr                      in   N*ADDR_WIDTH  address
//  client_axi_{aw,ar}len/size/burst/lock/prot  in   N*{8,3,2,1,3}  burst attributes
//  client_axi_{aw,ar}id                        in   N*ID_WIDTH  transaction ID
//  client_axi_wvalid / wready                  in/out N     write data handshake
//  client_axi_wdata/wstrb/wlast                in   N*{DATA_WIDTH,DATA_STROBES,1}  write beat
//  client_axi_bvalid / bready                  out/in N     write response handshake
//  client_axi_bresp/bid                        out  N*{2,ID_WIDTH}  write response
//  client_axi_rvalid / rready                  out/in N     read data handshake
//  client_axi_rresp/rlast/rdata/rid            out  N*{2,1,DATA_WIDTH,ID_WIDTH}  read beat
//  host_axi_*                                  (mirror) 1 copy  same signals, opposite direction
// BEHAVIOUR
//  Reset: all client_* and host_* valid/ready outputs 0, payload outputs 0; rstate=R_IDLE,
//   wstate=W_IDLE; r_last/w_last = N-1, so master 0 has first priority.
//  Round-robin pick: from candidates with valid=1, choose the first index after last, wrapping
//   modulo N. Picks are combinational from registered last; grant is registered.
//  Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE
//   R_IDLE: all arready=0, host arvalid=0. If any client arvalid, then r_grant<=pick and go to
//    R_ADDR. This costs a 1-cycle arbitration bubble.
//   R_ADDR: host AR fields = client[r_grant] AR fields; arready fans back only to r_grant.
//    On host arvalid&&arready, go to R_DATA.
//   R_DATA: host R routed to client[r_grant]; host rready = client rready[r_grant];
//    rvalid to every other master = 0. On rvalid&&rready&&rlast, r_last<=r_grant and go to R_IDLE.
//  Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE
//   W_IDLE: arbitrate on awvalid only, same as the read FSM, using w_grant/w_last.
//   W_ADDR: forward AW of w_grant. wready=0 to all masters. A master may hold W valid early;
//    it stalls.
//   W_DATA: forward W of w_grant. Leave on handshake with wlast=1; a beat count is not checked.
//   W_RESP: forward B to w_grant. On bvalid&&bready, w_last<=w_grant and go to W_IDLE.
//  Masters not granted see ready=0 and response valid=0 on every channel, every cycle.
//  AXI rule: a forwarded valid, once asserted, is never dropped by the arbiter before its
//   handshake. The grant is stable for the whole burst.
//  Read and write FSMs are fully independent. Same-cycle requests on both may go to the same or
//   different masters.
//  N=1: the pick is always 0, with the same bubble.
//  Rst mid-burst: the FSMs abort immediately to idle. Downstream must be reset in the same cycle.
//   No recovery of partial bursts.
//  No address decode and no ID remap; bid/rid are returned exactly as the downstream reports them.
// TESTING
//  T1 reset: hold rst 3 cycles, all inputs valid=1 -> every valid/ready output 0 during rst;
//   master0 granted first after release.
//  T2 single read: m1 arvalid, araddr=0x100, arlen=3, arid=5 -> host arvalid 1 cycle later;
//   4 beats reach m1 with rid=5 and rlast on beat 4; m0 rvalid stays 0 throughout.
//  T3 fairness: m0 and m1 both issue back-to-back single reads continuously for 20 bursts ->
//   grants alternate 0,1,0,1...; each master gets 10.
//  T4 write: m0 AW len=1 with W valid asserted early -> wready held 0 until AW handshake;
//   2 beats forwarded; bresp=OKAY, bid returned to m0; m1 bvalid stays 0.
//  T5 concurrency: m0 write and m1 read start in the same cycle -> both proceed in parallel and
//   complete with no cross-routing.
//  T6 reset mid-burst: rst asserted on beat 2 of a 4-beat read -> next cycle R_IDLE; new request
//   is served cleanly; check with an assertion monitor on AXI valid stability.

Source files
------------

// File: rtl/armleocpu_axi_arbiter.sv
// N-to-1 AXI4 arbiter: OPT_NUMBER_OF_HOSTS masters share one downstream port; read and
// write channels are arbitrated independently, round-robin, one outstanding burst each.
// Latency: one idle arbitration cycle before each address phase, then pure pass-through.
// Backpressure: ready/valid pass straight through for the granted master only; all other
// masters see ready=0 and response valid=0 until the burst finishes.
// Ports: clk, rst (sync, active-high); client_axi_* = per-master packed AXI4 slave side
// (master i at slice i); host_axi_* = single downstream AXI4 master side.
module armleocpu_axi_arbiter #(
   parameter int ADDR_WIDTH          = 34,
   parameter int DATA_WIDTH          = 32,
   parameter int ID_WIDTH            = 4,
   parameter int OPT_NUMBER_OF_HOSTS = 2
) (
   input  logic                                        clk,
   input  logic                                        rst,
   // client write address
   input  logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_awvalid,
   output logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_awready,
   input  logic [OPT_NUMBER_OF_HOSTS*ADDR_WIDTH-1:0]   client_axi_awaddr,
   input  logic [OPT_NUMBER_OF_HOSTS*8-1:0]            client_axi_awlen,
   input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]            client_axi_awsize,
   input  logic [OPT_NUMBER_OF_HOSTS*2-1:0]            client_axi_awburst,
   input  logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_awlock,
   input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]            client_axi_awprot,
   input  logic [OPT_NUMBER_OF_HOSTS*ID_WIDTH-1:0]     client_axi_awid,
   // client write data
   input  logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_wvalid,
   output logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_wready,
   input  logic [OPT_NUMBER_OF_HOSTS*DATA_WIDTH-1:0]   client_axi_wdata,
   input  logic [OPT_NUMBER_OF_HOSTS*DATA_WIDTH/8-1:0] client_axi_wstrb,
   input  logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_wlast,
   // client write response
   output logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_bvalid,
   input  logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_bready,
   output logic [OPT_NUMBER_OF_HOSTS*2-1:0]            client_axi_bresp,
   output logic [OPT_NUMBER_OF_HOSTS*ID_WIDTH-1:0]     client_axi_bid,
   // client read address
   input  logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_arvalid,
   output logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_arready,
   input  logic [OPT_NUMBER_OF_HOSTS*ADDR_WIDTH-1:0]   client_axi_araddr,
   input  logic [OPT_NUMBER_OF_HOSTS*8-1:0]            client_axi_arlen,
   input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]            client_axi_arsize,
   input  logic [OPT_NUMBER_OF_HOSTS*2-1:0]            client_axi_arburst,
   input  logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_arlock,
   input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]            client_axi_arprot,
   input  logic [OPT_NUMBER_OF_HOSTS*ID_WIDTH-1:0]     client_axi_arid,
   // client read data
   output logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_rvalid,
   input  logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_rready,
   output logic [OPT_NUMBER_OF_HOSTS*2-1:0]            client_axi_rresp,
   output logic [OPT_NUMBER_OF_HOSTS-1:0]              client_axi_rlast,
   output logic [OPT_NUMBER_OF_HOSTS*DATA_WIDTH-1:0]   client_axi_rdata,
   output logic [OPT_NUMBER_OF_HOSTS*ID_WIDTH-1:0]     client_axi_rid,
   // host (downstream) port
   output logic                                        host_axi_awvalid,
   input  logic                                        host_axi_awready,
   output logic [ADDR_WIDTH-1:0]                       host_axi_awaddr,
   output logic [7:0]                                  host_axi_awlen,
   output logic [2:0]                                  host_axi_awsize,
   output logic [1:0]                                  host_axi_awburst,
   output logic                                        host_axi_awlock,
   output logic [2:0]                                  host_axi_awprot,
   output logic [ID_WIDTH-1:0]                         host_axi_awid,
   output logic                                        host_axi_wvalid,
   input  logic                                        host_axi_wready,
   output logic [DATA_WIDTH-1:0]                       host_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]                     host_axi_wstrb,
   output logic                                        host_axi_wlast,
   input  logic                                        host_axi_bvalid,
   output logic                                        host_axi_bready,
   input  logic [1:0]                                  host_axi_bresp,
   input  logic [ID_WIDTH-1:0]                         host_axi_bid,
   output logic                                        host_axi_arvalid,
   input  logic                                        host_axi_arready,
   output logic [ADDR_WIDTH-1:0]                       host_axi_araddr,
   output logic [7:0]                                  host_axi_arlen,
   output logic [2:0]                                  host_axi_arsize,
   output logic [1:0]                                  host_axi_arburst,
   output logic                                        host_axi_arlock,
   output logic [2:0]                                  host_axi_arprot,
   output logic [ID_WIDTH-1:0]                         host_axi_arid,
   input  logic                                        host_axi_rvalid,
   output logic                                        host_axi_rready,
   input  logic [1:0]                                  host_axi_rresp,
   input  logic                                        host_axi_rlast,
   input  logic [DATA_WIDTH-1:0]                       host_axi_rdata,
   input  logic [ID_WIDTH-1:0]                         host_axi_rid
);

   localparam int N  = OPT_NUMBER_OF_HOSTS;
   localparam int DS = DATA_WIDTH / 8;
   localparam int GW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rstate_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wstate_t;

   rstate_t         rstate;
   wstate_t         wstate;
   logic [GW-1:0]   r_grant, r_last, r_pick;
   logic [GW-1:0]   w_grant, w_last, w_pick;

   // First requester strictly after 'last', wrapping; the previous winner is checked last.
   function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] req, input logic [GW-1:0] last);
      logic [GW-1:0] sel;
      logic          found;
      int            idx;
      sel   = '0;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(last) + i) % N;
         if (!found && req[idx]) begin
            sel   = GW'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign r_pick = rr_pick(client_axi_arvalid, r_last);
   assign w_pick = rr_pick(client_axi_awvalid, w_last);

   // Phase qualifiers also mask on rst so outputs are quiet for the whole reset window,
   // including the cycle in which rst is first seen.
   logic ar_phase, r_phase, aw_phase, w_phase, b_phase;
   assign ar_phase = !rst && (rstate == R_ADDR);
   assign r_phase  = !rst && (rstate == R_DATA);
   assign aw_phase = !rst && (wstate == W_ADDR);
   assign w_phase  = !rst && (wstate == W_DATA);
   assign b_phase  = !rst && (wstate == W_RESP);

   always_ff @(posedge clk) begin
      if (rst) begin
         rstate  <= R_IDLE;
         r_grant <= '0;
         r_last  <= GW'(N - 1);
      end else begin
         case (rstate)
            R_IDLE: if (|client_axi_arvalid) begin
               r_grant <= r_pick;
               rstate  <= R_ADDR;
            end
            R_ADDR: if (host_axi_arvalid && host_axi_arready) rstate <= R_DATA;
            R_DATA: if (host_axi_rvalid && host_axi_rready && host_axi_rlast) begin
               r_last <= r_grant;
               rstate <= R_IDLE;
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate  <= W_IDLE;
         w_grant <= '0;
         w_last  <= GW'(N - 1);
      end else begin
         case (wstate)
            W_IDLE: if (|client_axi_awvalid) begin
               w_grant <= w_pick;
               wstate  <= W_ADDR;
            end
            W_ADDR: if (host_axi_awvalid && host_axi_awready) wstate <= W_DATA;
            // Burst end is taken from wlast alone; beats are not counted against awlen.
            W_DATA: if (host_axi_wvalid && host_axi_wready && host_axi_wlast) wstate <= W_RESP;
            W_RESP: if (host_axi_bvalid && host_axi_bready) begin
               w_last <= w_grant;
               wstate <= W_IDLE;
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   always_comb begin
      host_axi_arvalid = ar_phase && client_axi_arvalid[r_grant];
      host_axi_araddr  = ar_phase ? client_axi_araddr[r_grant*ADDR_WIDTH +: ADDR_WIDTH] : '0;
      host_axi_arlen   = ar_phase ? client_axi_arlen[r_grant*8 +: 8] : '0;
      host_axi_arsize  = ar_phase ? client_axi_arsize[r_grant*3 +: 3] : '0;
      host_axi_arburst = ar_phase ? client_axi_arburst[r_grant*2 +: 2] : '0;
      host_axi_arlock  = ar_phase && client_axi_arlock[r_grant];
      host_axi_arprot  = ar_phase ? client_axi_arprot[r_grant*3 +: 3] : '0;
      host_axi_arid    = ar_phase ? client_axi_arid[r_grant*ID_WIDTH +: ID_WIDTH] : '0;
      host_axi_rready  = r_phase && client_axi_rready[r_grant];
      client_axi_arready = '0;
      client_axi_rvalid  = '0;
      client_axi_rresp   = '0;
      client_axi_rlast   = '0;
      client_axi_rdata   = '0;
      client_axi_rid     = '0;
      if (ar_phase) client_axi_arready[r_grant] = host_axi_arready;
      if (r_phase) begin
         client_axi_rvalid[r_grant]                           = host_axi_rvalid;
         client_axi_rresp[r_grant*2 +: 2]                     = host_axi_rresp;
         client_axi_rlast[r_grant]                            = host_axi_rlast;
         client_axi_rdata[r_grant*DATA_WIDTH +: DATA_WIDTH]   = host_axi_rdata;
         client_axi_rid[r_grant*ID_WIDTH +: ID_WIDTH]         = host_axi_rid;
      end
   end

   always_comb begin
      host_axi_awvalid = aw_phase && client_axi_awvalid[w_grant];
      host_axi_awaddr  = aw_phase ? client_axi_awaddr[w_grant*ADDR_WIDTH +: ADDR_WIDTH] : '0;
      host_axi_awlen   = aw_phase ? client_axi_awlen[w_grant*8 +: 8] : '0;
      host_axi_awsize  = aw_phase ? client_axi_awsize[w_grant*3 +: 3] : '0;
      host_axi_awburst = aw_phase ? client_axi_awburst[w_grant*2 +: 2] : '0;
      host_axi_awlock  = aw_phase && client_axi_awlock[w_grant];
      host_axi_awprot  = aw_phase ? client_axi_awprot[w_grant*3 +: 3] : '0;
      host_axi_awid    = aw_phase ? client_axi_awid[w_grant*ID_WIDTH +: ID_WIDTH] : '0;
      // Early W from the granted master stalls here until its AW has been accepted.
      host_axi_wvalid  = w_phase && client_axi_wvalid[w_grant];
      host_axi_wdata   = w_phase ? client_axi_wdata[w_grant*DATA_WIDTH +: DATA_WIDTH] : '0;
      host_axi_wstrb   = w_phase ? client_axi_wstrb[w_grant*DS +: DS] : '0;
      host_axi_wlast   = w_phase && client_axi_wlast[w_grant];
      host_axi_bready  = b_phase && client_axi_bready[w_grant];
      client_axi_awready = '0;
      client_axi_wready  = '0;
      client_axi_bvalid  = '0;
      client_axi_bresp   = '0;
      client_axi_bid     = '0;
      if (aw_phase) client_axi_awready[w_grant] = host_axi_awready;
      if (w_phase)  client_axi_wready[w_grant]  = host_axi_wready;
      if (b_phase) begin
         client_axi_bvalid[w_grant]                   = host_axi_bvalid;
         client_axi_bresp[w_grant*2 +: 2]             = host_axi_bresp;
         client_axi_bid[w_grant*ID_WIDTH +: ID_WIDTH] = host_axi_bid;
      end
   end

endmodule

// File: tb/tb_armleocpu_axi_arbiter.sv
// Directed bench for armleocpu_axi_arbiter with two masters and a hand-driven downstream.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_armleocpu_axi_arbiter;
   localparam int AW = 34, DW = 32, IW = 4, N = 2;

   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] client_axi_awvalid, client_axi_awready, client_axi_awlock;
   logic [N*AW-1:0] client_axi_awaddr, client_axi_araddr;
   logic [N*8-1:0] client_axi_awlen, client_axi_arlen;
   logic [N*3-1:0] client_axi_awsize, client_axi_awprot, client_axi_arsize, client_axi_arprot;
   logic [N*2-1:0] client_axi_awburst, client_axi_arburst, client_axi_bresp, client_axi_rresp;
   logic [N*IW-1:0] client_axi_awid, client_axi_arid, client_axi_bid, client_axi_rid;
   logic [N-1:0] client_axi_wvalid, client_axi_wready, client_axi_wlast;
   logic [N*DW-1:0] client_axi_wdata, client_axi_rdata;
   logic [N*DW/8-1:0] client_axi_wstrb;
   logic [N-1:0] client_axi_bvalid, client_axi_bready, client_axi_arvalid, client_axi_arready;
   logic [N-1:0] client_axi_arlock, client_axi_rvalid, client_axi_rready, client_axi_rlast;

   logic host_axi_awvalid, host_axi_awready, host_axi_awlock, host_axi_wvalid, host_axi_wready;
   logic [AW-1:0] host_axi_awaddr, host_axi_araddr;
   logic [7:0] host_axi_awlen, host_axi_arlen;
   logic [2:0] host_axi_awsize, host_axi_awprot, host_axi_arsize, host_axi_arprot;
   logic [1:0] host_axi_awburst, host_axi_arburst, host_axi_bresp, host_axi_rresp;
   logic [IW-1:0] host_axi_awid, host_axi_arid, host_axi_bid, host_axi_rid;
   logic [DW-1:0] host_axi_wdata, host_axi_rdata;
   logic [DW/8-1:0] host_axi_wstrb;
   logic host_axi_wlast, host_axi_bvalid, host_axi_bready, host_axi_arvalid, host_axi_arready;
   logic host_axi_arlock, host_axi_rvalid, host_axi_rready, host_axi_rlast;

   armleocpu_axi_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .OPT_NUMBER_OF_HOSTS(N)) dut (
      .clk(clk), .rst(rst),
      .client_axi_awvalid(client_axi_awvalid), .client_axi_awready(client_axi_awready),
      .client_axi_awaddr(client_axi_awaddr), .client_axi_awlen(client_axi_awlen),
      .client_axi_awsize(client_axi_awsize), .client_axi_awburst(client_axi_awburst),
      .client_axi_awlock(client_axi_awlock), .client_axi_awprot(client_axi_awprot),
      .client_axi_awid(client_axi_awid),
      .client_axi_wvalid(client_axi_wvalid), .client_axi_wready(client_axi_wready),
      .client_axi_wdata(client_axi_wdata), .client_axi_wstrb(client_axi_wstrb),
      .client_axi_wlast(client_axi_wlast),
      .client_axi_bvalid(client_axi_bvalid), .client_axi_bready(client_axi_bready),
      .client_axi_bresp(client_axi_bresp), .client_axi_bid(client_axi_bid),
      .client_axi_arvalid(client_axi_arvalid), .client_axi_arready(client_axi_arready),
      .client_axi_araddr(client_axi_araddr), .client_axi_arlen(client_axi_arlen),
      .client_axi_arsize(client_axi_arsize), .client_axi_arburst(client_axi_arburst),
      .client_axi_arlock(client_axi_arlock), .client_axi_arprot(client_axi_arprot),
      .client_axi_arid(client_axi_arid),
      .client_axi_rvalid(client_axi_rvalid), .client_axi_rready(client_axi_rready),
      .client_axi_rresp(client_axi_rresp), .client_axi_rlast(client_axi_rlast),
      .client_axi_rdata(client_axi_rdata), .client_axi_rid(client_axi_rid),
      .host_axi_awvalid(host_axi_awvalid), .host_axi_awready(host_axi_awready),
      .host_axi_awaddr(host_axi_awaddr), .host_axi_awlen(host_axi_awlen),
      .host_axi_awsize(host_axi_awsize), .host_axi_awburst(host_axi_awburst),
      .host_axi_awlock(host_axi_awlock), .host_axi_awprot(host_axi_awprot),
      .host_axi_awid(host_axi_awid),
      .host_axi_wvalid(host_axi_wvalid), .host_axi_wready(host_axi_wready),
      .host_axi_wdata(host_axi_wdata), .host_axi_wstrb(host_axi_wstrb),
      .host_axi_wlast(host_axi_wlast),
      .host_axi_bvalid(host_axi_bvalid), .host_axi_bready(host_axi_bready),
      .host_axi_bresp(host_axi_bresp), .host_axi_bid(host_axi_bid),
      .host_axi_arvalid(host_axi_arvalid), .host_axi_arready(host_axi_arready),
      .host_axi_araddr(host_axi_araddr), .host_axi_arlen(host_axi_arlen),
      .host_axi_arsize(host_axi_arsize), .host_axi_arburst(host_axi_arburst),
      .host_axi_arlock(host_axi_arlock), .host_axi_arprot(host_axi_arprot),
      .host_axi_arid(host_axi_arid),
      .host_axi_rvalid(host_axi_rvalid), .host_axi_rready(host_axi_rready),
      .host_axi_rresp(host_axi_rresp), .host_axi_rlast(host_axi_rlast),
      .host_axi_rdata(host_axi_rdata), .host_axi_rid(host_axi_rid)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Stall monitor: a host valid left unaccepted must still be high with the same payload
   // one cycle later, unless reset intervened. Sampled just before each rising edge.
   logic          p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_rst = 1'b1;
   logic [AW-1:0] p_araddr = '0, p_awaddr = '0;
   always @(negedge clk) begin
      #4;
      if (!p_rst && !rst && p_arv && !p_arr) begin
         check("mon_arvalid_held", host_axi_arvalid, 1);
         check("mon_araddr_stable", host_axi_araddr, p_araddr);
      end
      if (!p_rst && !rst && p_awv && !p_awr) begin
         check("mon_awvalid_held", host_axi_awvalid, 1);
         check("mon_awaddr_stable", host_axi_awaddr, p_awaddr);
      end
      p_arv = host_axi_arvalid; p_arr = host_axi_arready; p_araddr = host_axi_araddr;
      p_awv = host_axi_awvalid; p_awr = host_axi_awready; p_awaddr = host_axi_awaddr;
      p_rst = rst;
   end

   task automatic clear_inputs();
      client_axi_awvalid = '0; client_axi_awaddr = '0; client_axi_awlen = '0; client_axi_awsize = '0;
      client_axi_awburst = '0; client_axi_awlock = '0; client_axi_awprot = '0; client_axi_awid = '0;
      client_axi_wvalid = '0; client_axi_wdata = '0; client_axi_wstrb = '0; client_axi_wlast = '0;
      client_axi_bready = '0; client_axi_arvalid = '0; client_axi_araddr = '0; client_axi_arlen = '0;
      client_axi_arsize = '0; client_axi_arburst = '0; client_axi_arlock = '0; client_axi_arprot = '0;
      client_axi_arid = '0; client_axi_rready = '0;
      host_axi_awready = 1'b0; host_axi_wready = 1'b0; host_axi_bvalid = 1'b0; host_axi_bresp = '0;
      host_axi_bid = '0; host_axi_arready = 1'b0; host_axi_rvalid = 1'b0; host_axi_rresp = '0;
      host_axi_rlast = 1'b0; host_axi_rdata = '0; host_axi_rid = '0;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; clear_inputs();
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
   endtask

   function automatic logic [14:0] all_hs();
      return {host_axi_arvalid, host_axi_awvalid, host_axi_wvalid, host_axi_rready, host_axi_bready,
              client_axi_arready, client_axi_awready, client_axi_wready, client_axi_rvalid,
              client_axi_bvalid};
   endfunction

   int cnt0, cnt1, nb;
   logic pend;
   logic [IW-1:0] pend_id;
   logic [1:0] exp_route;

   initial begin
      clear_inputs();
      // T1: reset with every input valid/ready asserted
      @(negedge clk);
      rst = 1'b1;
      client_axi_arvalid = '1; client_axi_awvalid = '1; client_axi_wvalid = '1;
      client_axi_rready = '1; client_axi_bready = '1;
      host_axi_arready = 1'b1; host_axi_awready = 1'b1; host_axi_wready = 1'b1;
      host_axi_rvalid = 1'b1; host_axi_bvalid = 1'b1;
      client_axi_araddr = {34'h20, 34'h10};
      client_axi_awaddr = {34'h40, 34'h30};
      for (int c = 0; c < 3; c++) begin
         #1 check("t1_rst_quiet", all_hs(), 0);
         @(negedge clk);
      end
      rst = 1'b0; host_axi_rvalid = 1'b0; host_axi_bvalid = 1'b0; client_axi_wvalid = '0;
      #1 check("t1_idle_bubble", {host_axi_arvalid, host_axi_awvalid}, 0);
      @(negedge clk); #1;
      check("t1_ar_first_m0", host_axi_araddr, 34'h10);
      check("t1_arready_m0", client_axi_arready, 2'b01);
      check("t1_aw_first_m0", host_axi_awaddr, 34'h30);
      check("t1_awready_m0", client_axi_awready, 2'b01);

      // T2: single 4-beat read from m1, one stall cycle on AR
      do_reset();
      client_axi_arvalid = 2'b10;
      client_axi_araddr = {34'h100, 34'h0};
      client_axi_arlen = {8'd3, 8'd0};
      client_axi_arid = {4'd5, 4'd0};
      #1 check("t2_bubble", host_axi_arvalid, 0);
      @(negedge clk); #1;
      check("t2_arvalid", host_axi_arvalid, 1);
      check("t2_araddr", host_axi_araddr, 34'h100);
      check("t2_arlen", host_axi_arlen, 3);
      check("t2_arid", host_axi_arid, 5);
      @(negedge clk);
      host_axi_arready = 1'b1;
      #1 check("t2_arready_route", client_axi_arready, 2'b10);
      @(negedge clk);
      client_axi_arvalid = '0; host_axi_arready = 1'b0; client_axi_rready = 2'b11;
      for (int b = 0; b < 4; b++) begin
         host_axi_rvalid = 1'b1; host_axi_rid = 4'd5; host_axi_rdata = 32'hA0 + b;
         host_axi_rlast = (b == 3);
         #1;
         check("t2_rvalid_route", client_axi_rvalid, 2'b10);
         check("t2_rdata", client_axi_rdata[DW +: DW], 32'hA0 + b);
         check("t2_rid", client_axi_rid[IW +: IW], 5);
         check("t2_rlast", client_axi_rlast, (b == 3) ? 2'b10 : 2'b00);
         check("t2_host_rready", host_axi_rready, 1);
         @(negedge clk);
      end
      host_axi_rvalid = 1'b0; host_axi_rlast = 1'b0;
      #1 check("t2_done_quiet", {host_axi_rready, client_axi_rvalid}, 0);

      // T3: both masters stream single-beat reads; grants must alternate
      do_reset();
      client_axi_arvalid = 2'b11;
      client_axi_araddr = {34'h2000, 34'h1000};
      client_axi_arid = {4'd1, 4'd0};
      client_axi_rready = 2'b11;
      host_axi_arready = 1'b1;
      cnt0 = 0; cnt1 = 0; nb = 0; pend = 1'b0; pend_id = '0;
      for (int cyc = 0; cyc < 200 && nb < 20; cyc++) begin
         if (cyc != 0) @(negedge clk);
         host_axi_rvalid = pend; host_axi_rlast = pend; host_axi_rid = pend_id;
         host_axi_rdata = 32'hC0 + nb;
         #1;
         if (host_axi_rvalid && host_axi_rready) begin
            exp_route = 2'b01 << pend_id;
            check("t3_r_route", client_axi_rvalid, exp_route);
            pend = 1'b0;
            nb++;
         end
         if (host_axi_arvalid && host_axi_arready) begin
            check("t3_grant_order", host_axi_arid, nb % 2);
            check("t3_addr_match", host_axi_araddr, (host_axi_arid == 4'd0) ? 34'h1000 : 34'h2000);
            if (host_axi_arid == 4'd0) cnt0++; else cnt1++;
            pend = 1'b1;
            pend_id = host_axi_arid;
         end
      end
      check("t3_bursts_done", nb, 20);
      check("t3_m0_count", cnt0, 10);
      check("t3_m1_count", cnt1, 10);

      // T4: m0 write, len=1, W valid presented before AW
      do_reset();
      client_axi_awvalid = 2'b01; client_axi_awaddr = {34'h0, 34'h200};
      client_axi_awlen = {8'd0, 8'd1}; client_axi_awid = {4'd0, 4'd3};
      client_axi_wvalid = 2'b01; client_axi_wdata = {32'h0, 32'h11};
      client_axi_wstrb = 8'h0F; client_axi_wlast = 2'b00;
      host_axi_wready = 1'b1;
      #1 check("t4_wready_idle", client_axi_wready, 0);
      @(negedge clk); #1;
      check("t4_awvalid", host_axi_awvalid, 1);
      check("t4_awaddr", host_axi_awaddr, 34'h200);
      check("t4_awid", host_axi_awid, 3);
      check("t4_w_blocked", {host_axi_wvalid, client_axi_wready}, 0);
      host_axi_awready = 1'b1;
      #1 check("t4_awready_route", client_axi_awready, 2'b01);
      check("t4_wready_aw", client_axi_wready, 0);
      @(negedge clk);
      client_axi_awvalid = '0; host_axi_awready = 1'b0;
      #1 check("t4_beat1", {host_axi_wvalid, host_axi_wlast, host_axi_wdata}, {1'b1, 1'b0, 32'h11});
      check("t4_wready_route", client_axi_wready, 2'b01);
      @(negedge clk);
      client_axi_wdata = {32'h0, 32'h22}; client_axi_wlast = 2'b01;
      #1 check("t4_beat2", {host_axi_wvalid, host_axi_wlast, host_axi_wdata}, {1'b1, 1'b1, 32'h22});
      @(negedge clk);
      client_axi_wvalid = '0; client_axi_wlast = '0;
      host_axi_bvalid = 1'b1; host_axi_bresp = 2'b00; host_axi_bid = 4'd3;
      client_axi_bready = 2'b11;
      #1 check("t4_bvalid_route", client_axi_bvalid, 2'b01);
      check("t4_bid", client_axi_bid[0 +: IW], 3);
      check("t4_bresp", client_axi_bresp, 0);
      check("t4_bready", host_axi_bready, 1);
      @(negedge clk);
      host_axi_bvalid = 1'b0;
      #1 check("t4_b_done", {client_axi_bvalid, host_axi_bready}, 0);

      // T5: m0 write and m1 read start together
      do_reset();
      client_axi_awvalid = 2'b01; client_axi_awaddr = {34'h0, 34'h300}; client_axi_awid = {4'd0, 4'd1};
      client_axi_wvalid = 2'b01; client_axi_wdata = {32'h0, 32'h55}; client_axi_wlast = 2'b01;
      client_axi_arvalid = 2'b10; client_axi_araddr = {34'h400, 34'h0}; client_axi_arid = {4'd2, 4'd0};
      host_axi_awready = 1'b1; host_axi_arready = 1'b1; host_axi_wready = 1'b1;
      #1 check("t5_bubble", {host_axi_awvalid, host_axi_arvalid}, 0);
      @(negedge clk); #1;
      check("t5_awaddr", host_axi_awaddr, 34'h300);
      check("t5_araddr", host_axi_araddr, 34'h400);
      check("t5_addr_ready", {client_axi_awready, client_axi_arready}, 4'b0110);
      @(negedge clk);
      client_axi_awvalid = '0; client_axi_arvalid = '0;
      host_axi_rvalid = 1'b1; host_axi_rlast = 1'b1; host_axi_rid = 4'd2; host_axi_rdata = 32'h77;
      client_axi_rready = 2'b11;
      #1 check("t5_w_fwd", {host_axi_wvalid, host_axi_wdata}, {1'b1, 32'h55});
      check("t5_ready_route", {client_axi_wready, client_axi_rvalid}, 4'b0110);
      check("t5_rdata", client_axi_rdata[DW +: DW], 32'h77);
      @(negedge clk);
      client_axi_wvalid = '0; host_axi_rvalid = 1'b0; host_axi_rlast = 1'b0;
      host_axi_bvalid = 1'b1; host_axi_bid = 4'd1; client_axi_bready = 2'b11;
      #1 check("t5_resp_route", {client_axi_bvalid, client_axi_rvalid}, 4'b0100);
      check("t5_bid", client_axi_bid[0 +: IW], 1);
      @(negedge clk);
      host_axi_bvalid = 1'b0;
      #1 check("t5_done", {client_axi_bvalid, client_axi_rvalid}, 0);

      // T6: reset on beat 2 of a 4-beat read, then a clean new read
      do_reset();
      client_axi_arvalid = 2'b01; client_axi_araddr = {34'h0, 34'h500};
      client_axi_arlen = {8'd0, 8'd3}; client_axi_arid = {4'd0, 4'd7};
      host_axi_arready = 1'b1; client_axi_rready = 2'b11;
      @(negedge clk);
      #1 check("t6_ar", {host_axi_arvalid, host_axi_araddr}, {1'b1, 34'h500});
      @(negedge clk);
      client_axi_arvalid = '0;
      host_axi_rvalid = 1'b1; host_axi_rid = 4'd7; host_axi_rdata = 32'hB0;
      #1 check("t6_beat1", client_axi_rvalid, 2'b01);
      @(negedge clk);
      host_axi_rdata = 32'hB1; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; host_axi_rvalid = 1'b0;
      client_axi_arvalid = 2'b10; client_axi_araddr = {34'h600, 34'h0};
      client_axi_arlen = '0; client_axi_arid = {4'd4, 4'd0};
      #1 check("t6_idle_after_rst", {host_axi_arvalid, client_axi_rvalid, host_axi_rready}, 0);
      @(negedge clk); #1;
      check("t6_new_ar", {host_axi_arvalid, host_axi_araddr, host_axi_arid}, {1'b1, 34'h600, 4'd4});
      check("t6_new_arready", client_axi_arready, 2'b10);
      @(negedge clk);
      client_axi_arvalid = '0;
      host_axi_rvalid = 1'b1; host_axi_rlast = 1'b1; host_axi_rid = 4'd4;
      #1 check("t6_new_r_route", client_axi_rvalid, 2'b10);
      check("t6_new_rid", client_axi_rid[IW +: IW], 4);
      @(negedge clk);
      host_axi_rvalid = 1'b0; host_axi_rlast = 1'b0;
      #1 check("t6_final_idle", client_axi_rvalid, 0);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
